sr_pulse_gen: RTL and testbench
===============================

# sr_pulse_gen

Drives the S/R input pair of the set/reset flip-flop from a single noisy level request. Synchronises and debounces `level_in`, then emits a registered, width-controlled set pulse on a qualified rising level and a reset pulse on a qualified falling level, plus a forced-clear path. Sits between pushbutton/controller logic and the `FlipFlopRS` instance and guarantees S and R are never high together.

## Interface
- `DEB_CYCLES`, 4: consecutive identical samples required to qualify a level change (min 2, max 2^CNT_W−1).
- `PULSE_CYCLES`, 1: width of each S or R pulse in clocks (min 1).
- `CNT_W`, 8: width of the shared debounce/pulse counter.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `level_in`  in  1  asynchronous level request (1 = set Q, 0 = reset Q).
- `force_clr`  in  1  synchronous single-cycle request to drive Q low regardless of `level_in`.
- `S`  out  1  set pulse to flip-flop, registered.
- `R`  out  1  reset pulse to flip-flop, registered.
- `q_shadow`  out  1  expected flip-flop Q after the last issued pulse.
- `busy`  out  1  high in any state other than IDLE_LOW/IDLE_HIGH.

## Operation
- `lvl_s` is the sampled level: output of the 2-flop synchroniser (see Configuration) or raw `level_in`.
- States: IDLE_LOW, DEB_RISE, PULSE_S, IDLE_HIGH, DEB_FALL, PULSE_R, LOCKOUT.
- IDLE_LOW: `lvl_s`=1 → DEB_RISE, cnt=1.
- DEB_RISE: `lvl_s`=0 → IDLE_LOW (glitch rejected, no pulse); `lvl_s`=1 and cnt=DEB_CYCLES−1 → PULSE_S, cnt=0; else cnt+1.
- PULSE_S: S=1 for PULSE_CYCLES clocks, then → IDLE_HIGH, `q_shadow`=1. `level_in` is ignored during the pulse.
- IDLE_HIGH/DEB_FALL/PULSE_R: mirror images of the above, with R and `q_shadow`=0. PULSE_R → IDLE_LOW.
- `force_clr` in IDLE_HIGH or DEB_FALL → PULSE_R, then LOCKOUT instead of IDLE_LOW. LOCKOUT holds until `lvl_s`=0, then → IDLE_LOW. This prevents an immediate re-set while the request is still high.
- `force_clr` in any other state is ignored. In PULSE_S it is not queued.
- S and R are mutually exclusive by construction. Neither is ever high for more than PULSE_CYCLES consecutive clocks.
- Counter saturates and never wraps. Out-of-range parameters are a configuration error (elaboration-time check).

## Timing
- All outputs are registered, with no combinational path from inputs.
- Reset (`rst_n`=0 at an edge): state=IDLE_LOW, S=0, R=0, `q_shadow`=0, `busy`=0, counter=0, synchroniser=0. A pulse in progress is truncated at that edge.
- Let e0 be the first edge that samples `level_in`=1 with the level held stable afterwards.
  - With SR_SYNC_EN: S is high in the cycles following edges e0+DEB_CYCLES+1 … e0+DEB_CYCLES+PULSE_CYCLES.
  - Without SR_SYNC_EN: same window shifted 2 edges earlier.
- Falling path has identical latency with R.
- `force_clr` sampled at edge f: R is high after edges f+1 … f+PULSE_CYCLES.

## Configuration
- `SR_PULSE_SYNC_EN` defined: `level_in` passes through a 2-flop synchroniser before the FSM, adding +2 clocks latency.
- Not defined: `lvl_s` = `level_in` directly. Use only when the source is already synchronous to `clk`.

## Structure
- Package `sr_pulse_pkg`: state encoding constants (7 states, 3-bit), parameter min/max limits.
- One sub-module, `sync_2ff`: 2-flop synchroniser with synchronous active-low reset to 0. It is instantiated only under `SR_PULSE_SYNC_EN`.
- Debounce and pulse timing share one counter in the top.

## Test plan
- Reset: hold `rst_n`=0 for 3 clocks with `level_in`=1 → S=R=0, `q_shadow`=0, `busy`=0. After release, S pulses at the documented edge.
- Clean rise, DEB_CYCLES=4, PULSE_CYCLES=1, sync on: `level_in` 0→1 sampled at e0 → S=1 only in the cycle after e0+5, then `q_shadow`=1. R stays 0 throughout.
- Glitch: `level_in` high for 2 clocks, then low → no S pulse; state returns to IDLE_LOW; `busy` drops.
- Fall with PULSE_CYCLES=3: after a settled high, `level_in`→0 → R high for exactly 3 cycles, then `q_shadow`=0.
- `force_clr` in IDLE_HIGH with `level_in` held 1 → R pulse, then LOCKOUT with no S. Then `level_in`=0 for 4 clocks, then 1 → a normal S pulse follows.
- Reset asserted mid-PULSE_S with PULSE_CYCLES=4 → S=0 after that edge, all outputs at reset values. Check S&R never 1 in any cycle via assertion.

Source files
------------

// File: rtl/sr_pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_pulse_pkg
// Brief    : Shared types and limits for the S/R pulse generator: FSM state
//            encoding and legal parameter ranges.
// Revision : 1.0 - initial release
// ============================================================================
package sr_pulse_pkg;

    // Seven FSM states in a 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE_LOW  = 3'd0,
        DEB_RISE  = 3'd1,
        PULSE_S   = 3'd2,
        IDLE_HIGH = 3'd3,
        DEB_FALL  = 3'd4,
        PULSE_R   = 3'd5,
        LOCKOUT   = 3'd6
    } state_t;

    // Legal parameter limits.
    localparam int c_deb_cycles_min   = 2;
    localparam int c_pulse_cycles_min = 1;
    localparam int c_cnt_w_min        = 2;
    localparam int c_cnt_w_max        = 30;

    // Largest value a counter of width w can hold.
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_pulse_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : sr_pulse_gen_if
// Brief    : Signal bundle between the request source and the S/R pulse
//            generator. master = request source, slave = pulse generator.
// Revision : 1.0 - initial release
// ============================================================================
interface sr_pulse_gen_if;
    logic level_in;
    logic force_clr;
    logic S;
    logic R;
    logic q_shadow;
    logic busy;

    modport master (
        output level_in,
        output force_clr,
        input  S,
        input  R,
        input  q_shadow,
        input  busy
    );

    modport slave (
        input  level_in,
        input  force_clr,
        output S,
        output R,
        output q_shadow,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/sr_pulse_gen_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchroniser for a single asynchronous bit, with a
//            synchronous active-low reset that clears both stages to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  wire clk,
    input  wire rst_n,
    input  wire d,
    output wire q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture; the first stage may go metastable, the second settles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/sr_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : sr_pulse_gen
// Brief    : Debounces a level request and drives mutually exclusive,
//            width-controlled S/R pulses for a set/reset flip-flop, with a
//            forced-clear path followed by a lockout until the request drops.
//            Optional macro SR_PULSE_SYNC_EN inserts a 2-flop synchroniser on
//            level_in (+2 clocks latency); without it level_in must already
//            be synchronous to clk.
// Revision : 1.0 - initial release
// ============================================================================
module sr_pulse_gen
    import sr_pulse_pkg::*;
#(
    parameter int DEB_CYCLES   = 4,
    parameter int PULSE_CYCLES = 1,
    parameter int CNT_W        = 8
) (
    input  wire          clk,
    input  wire          rst_n,
    sr_pulse_gen_if.slave bus
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter range checks
    // ------------------------------------------------------------------
    if (CNT_W < c_cnt_w_min || CNT_W > c_cnt_w_max) begin : g_bad_cnt_w
        $error("sr_pulse_gen: CNT_W out of range");
    end
    if (DEB_CYCLES < c_deb_cycles_min || DEB_CYCLES > cnt_max(CNT_W)) begin : g_bad_deb
        $error("sr_pulse_gen: DEB_CYCLES out of range");
    end
    if (PULSE_CYCLES < c_pulse_cycles_min || PULSE_CYCLES > cnt_max(CNT_W)) begin : g_bad_pulse
        $error("sr_pulse_gen: PULSE_CYCLES out of range");
    end

    localparam logic [CNT_W-1:0] c_deb_last   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_pulse_last = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    // ------------------------------------------------------------------
    // Sampled level
    // ------------------------------------------------------------------
    wire w_lvl_s;

`ifdef SR_PULSE_SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.level_in),
        .q     (w_lvl_s)
    );
`else
    assign w_lvl_s = bus.level_in;
`endif

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic             r_s,     w_s_nxt;
    logic             r_r,     w_r_nxt;
    logic             r_q,     w_q_nxt;
    logic             r_busy,  w_busy_nxt;
    logic             r_lock,  w_lock_nxt;   // current R pulse came from force_clr
    logic [CNT_W-1:0] w_cnt_inc;

    // Shared counter increments but saturates instead of wrapping.
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + c_cnt_one;

    // State register and registered outputs; reset truncates any pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_q     <= 1'b0;
            r_busy  <= 1'b0;
            r_lock  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_s     <= w_s_nxt;
            r_r     <= w_r_nxt;
            r_q     <= w_q_nxt;
            r_busy  <= w_busy_nxt;
            r_lock  <= w_lock_nxt;
        end
    end

    // Next-state, counter and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_s_nxt     = 1'b0;
        w_r_nxt     = 1'b0;
        w_q_nxt     = r_q;
        w_lock_nxt  = r_lock;

        case (r_state)
            IDLE_LOW: begin
                if (w_lvl_s) begin
                    w_state_nxt = DEB_RISE;
                    w_cnt_nxt   = c_cnt_one;
                end
            end

            DEB_RISE: begin
                if (!w_lvl_s) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt = PULSE_S;
                    w_cnt_nxt   = '0;
                    w_s_nxt     = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end

            // Input is ignored while the set pulse runs, including force_clr.
            PULSE_S: begin
                if (r_cnt == c_pulse_last) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                    w_q_nxt     = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_s_nxt     = 1'b1;
                end
            end

            IDLE_HIGH: begin
                if (bus.force_clr) begin
                    w_state_nxt = PULSE_R;
                    w_cnt_nxt   = '0;
                    w_lock_nxt  = 1'b1;
                end else if (!w_lvl_s) begin
                    w_state_nxt = DEB_FALL;
                    w_cnt_nxt   = c_cnt_one;
                end
            end

            DEB_FALL: begin
                if (bus.force_clr) begin
                    w_state_nxt = PULSE_R;
                    w_cnt_nxt   = '0;
                    w_lock_nxt  = 1'b1;
                end else if (w_lvl_s) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt = PULSE_R;
                    w_cnt_nxt   = '0;
                    w_r_nxt     = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end

            // A forced entry arrives with R still low, so the first cycle
            // here only raises R; the width count starts once R is high.
            PULSE_R: begin
                if (!r_r) begin
                    w_r_nxt     = 1'b1;
                end else if (r_cnt == c_pulse_last) begin
                    w_state_nxt = r_lock ? LOCKOUT : IDLE_LOW;
                    w_cnt_nxt   = '0;
                    w_q_nxt     = 1'b0;
                    w_lock_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_r_nxt     = 1'b1;
                end
            end

            // Blocks an immediate re-set while the request is still high.
            LOCKOUT: begin
                if (!w_lvl_s) begin
                    w_state_nxt = IDLE_LOW;
                end
            end

            default: begin
                w_state_nxt = IDLE_LOW;
                w_cnt_nxt   = '0;
                w_lock_nxt  = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE_LOW) && (w_state_nxt != IDLE_HIGH);
    end

    assign bus.S        = r_s;
    assign bus.R        = r_r;
    assign bus.q_shadow = r_q;
    assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sr_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_pulse_gen
// Brief    : Self-checking bench for sr_pulse_gen (DEB_CYCLES=4,
//            PULSE_CYCLES=3). Expected per-cycle S/R/q_shadow/busy values are
//            derived from the documented edge timing and queued when the
//            stimulus is applied, then popped one per clock. Latency adapts
//            to SR_PULSE_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_pulse_gen;

    localparam int DEB = 4;
    localparam int P   = 3;
`ifdef SR_PULSE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    // Edges after e0 until the pulse register first goes high.
    localparam int L = DEB - 1 + SYNC;

    typedef struct {
        logic s;
        logic r;
        logic q;
        logic busy;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sbq[$];
    exp_t e;
    int   s_run;
    int   r_run;

    sr_pulse_gen_if bus ();

    sr_pulse_gen #(
        .DEB_CYCLES   (DEB),
        .PULSE_CYCLES (P),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Continuous safety monitor: S/R exclusivity and pulse width bound.
    always @(negedge clk) begin
        assert (!(bus.S === 1'b1 && bus.R === 1'b1))
            else $error("S and R high together");
        if (bus.S === 1'b1 && bus.R === 1'b1) begin
            failures++;
            $display("FAIL sr_exclusive got S=1 R=1 required not both");
        end
        s_run = (bus.S === 1'b1) ? s_run + 1 : 0;
        r_run = (bus.R === 1'b1) ? r_run + 1 : 0;
        if (s_run > P || r_run > P) begin
            failures++;
            $display("FAIL pulse_width got run S=%0d R=%0d required <= %0d", s_run, r_run, P);
        end
    end

    // Expected response to a level change applied just before edge e0.
    task automatic push_level(input logic up, input int n, input logic q_before);
        exp_t x;
        logic pulse;
        for (int k = 0; k < n; k++) begin
            pulse  = (k >= L) && (k <= L + P - 1);
            x.s    = up & pulse;
            x.r    = ~up & pulse;
            x.q    = (k >= L + P) ? up : q_before;
            x.busy = (k >= SYNC) && (k < L + P);
            sbq.push_back(x);
        end
    endtask

    task automatic test_reset();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if ({bus.S, bus.R, bus.q_shadow, bus.busy} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got S/R/q/busy=%b%b%b%b required 0000",
                         j, bus.S, bus.R, bus.q_shadow, bus.busy);
            end
        end
        rst_n = 1'b1;
        push_level(1'b1, L + P + 2, 1'b0);
        for (int j = 1; j <= L + P + 2; j++) begin
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ({bus.S, bus.R, bus.q_shadow, bus.busy} !== {e.s, e.r, e.q, e.busy}) begin
                failures++;
                $display("FAIL reset_release_rise k=%0d got S/R/q/busy=%b%b%b%b required %b%b%b%b",
                         j - 1, bus.S, bus.R, bus.q_shadow, bus.busy, e.s, e.r, e.q, e.busy);
            end
        end
    endtask

    task automatic test_fall();
        bus.level_in = 1'b0;
        push_level(1'b0, L + P + 2, 1'b1);
        for (int j = 1; j <= L + P + 2; j++) begin
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ({bus.S, bus.R, bus.q_shadow, bus.busy} !== {e.s, e.r, e.q, e.busy}) begin
                failures++;
                $display("FAIL fall k=%0d got S/R/q/busy=%b%b%b%b required %b%b%b%b",
                         j - 1, bus.S, bus.R, bus.q_shadow, bus.busy, e.s, e.r, e.q, e.busy);
            end
        end
    endtask

    // High for n_high edges (fewer than DEB) then low: no pulse at all.
    task automatic test_glitch(input int n_high);
        exp_t x;
        int   m;
        m = n_high + SYNC + 3;
        bus.level_in = 1'b1;
        for (int k = 0; k < m; k++) begin
            x.s = 1'b0; x.r = 1'b0; x.q = 1'b0;
            x.busy = (k >= SYNC) && (k < SYNC + n_high);
            sbq.push_back(x);
        end
        for (int j = 1; j <= m; j++) begin
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ({bus.S, bus.R, bus.q_shadow, bus.busy} !== {e.s, e.r, e.q, e.busy}) begin
                failures++;
                $display("FAIL glitch%0d k=%0d got S/R/q/busy=%b%b%b%b required %b%b%b%b",
                         n_high, j - 1, bus.S, bus.R, bus.q_shadow, bus.busy, e.s, e.r, e.q, e.busy);
            end
            if (j == n_high) bus.level_in = 1'b0;
        end
    endtask

    task automatic test_force_ignored_low();
        exp_t x;
        bus.force_clr = 1'b1;
        x.s = 1'b0; x.r = 1'b0; x.q = 1'b0; x.busy = 1'b0;
        for (int k = 0; k < 4; k++) sbq.push_back(x);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ({bus.S, bus.R, bus.q_shadow, bus.busy} !== {e.s, e.r, e.q, e.busy}) begin
                failures++;
                $display("FAIL force_in_idle_low k=%0d got S/R/q/busy=%b%b%b%b required %b%b%b%b",
                         j - 1, bus.S, bus.R, bus.q_shadow, bus.busy, e.s, e.r, e.q, e.busy);
            end
            if (j == 1) bus.force_clr = 1'b0;
        end
    endtask

    // force_clr during the set pulse is dropped, not queued.
    task automatic test_force_in_pulse_s();
        bus.level_in = 1'b1;
        push_level(1'b1, L + P + 4, 1'b0);
        for (int j = 1; j <= L + P + 4; j++) begin
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ({bus.S, bus.R, bus.q_shadow, bus.busy} !== {e.s, e.r, e.q, e.busy}) begin
                failures++;
                $display("FAIL force_in_pulse_s k=%0d got S/R/q/busy=%b%b%b%b required %b%b%b%b",
                         j - 1, bus.S, bus.R, bus.q_shadow, bus.busy, e.s, e.r, e.q, e.busy);
            end
            bus.force_clr = (j == L + 1);
        end
    endtask

    // Forced clear from IDLE_HIGH, lockout, release, then a normal rise.
    task automatic test_force_clear();
        exp_t x;
        bus.force_clr = 1'b1;
        for (int k = 0; k < P + 4; k++) begin
            x.s = 1'b0;
            x.r = (k >= 1) && (k <= P);
            x.q = (k >= P + 1) ? 1'b0 : 1'b1;
            x.busy = 1'b1;
            sbq.push_back(x);
        end
        for (int j = 1; j <= P + 4; j++) begin
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ({bus.S, bus.R, bus.q_shadow, bus.busy} !== {e.s, e.r, e.q, e.busy}) begin
                failures++;
                $display("FAIL force_clear k=%0d got S/R/q/busy=%b%b%b%b required %b%b%b%b",
                         j - 1, bus.S, bus.R, bus.q_shadow, bus.busy, e.s, e.r, e.q, e.busy);
            end
            if (j == 1) bus.force_clr = 1'b0;
        end
        bus.level_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            x.s = 1'b0; x.r = 1'b0; x.q = 1'b0;
            x.busy = (k < SYNC);
            sbq.push_back(x);
        end
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ({bus.S, bus.R, bus.q_shadow, bus.busy} !== {e.s, e.r, e.q, e.busy}) begin
                failures++;
                $display("FAIL lockout_release k=%0d got S/R/q/busy=%b%b%b%b required %b%b%b%b",
                         j - 1, bus.S, bus.R, bus.q_shadow, bus.busy, e.s, e.r, e.q, e.busy);
            end
        end
        bus.level_in = 1'b1;
        push_level(1'b1, L + P + 2, 1'b0);
        for (int j = 1; j <= L + P + 2; j++) begin
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ({bus.S, bus.R, bus.q_shadow, bus.busy} !== {e.s, e.r, e.q, e.busy}) begin
                failures++;
                $display("FAIL rise_after_lockout k=%0d got S/R/q/busy=%b%b%b%b required %b%b%b%b",
                         j - 1, bus.S, bus.R, bus.q_shadow, bus.busy, e.s, e.r, e.q, e.busy);
            end
        end
    endtask

    // Reset lands in the middle of the set pulse and truncates it.
    task automatic test_reset_mid_pulse();
        bus.level_in = 1'b1;
        push_level(1'b1, L + 2, 1'b0);
        for (int j = 1; j <= L + 2; j++) begin
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ({bus.S, bus.R, bus.q_shadow, bus.busy} !== {e.s, e.r, e.q, e.busy}) begin
                failures++;
                $display("FAIL pre_reset_rise k=%0d got S/R/q/busy=%b%b%b%b required %b%b%b%b",
                         j - 1, bus.S, bus.R, bus.q_shadow, bus.busy, e.s, e.r, e.q, e.busy);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.S, bus.R, bus.q_shadow, bus.busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_pulse got S/R/q/busy=%b%b%b%b required 0000",
                     bus.S, bus.R, bus.q_shadow, bus.busy);
        end
        rst_n = 1'b1;
        bus.level_in = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if ({bus.S, bus.R, bus.q_shadow, bus.busy} !== 4'b0000) begin
                failures++;
                $display("FAIL post_reset_idle cyc=%0d got S/R/q/busy=%b%b%b%b required 0000",
                         j, bus.S, bus.R, bus.q_shadow, bus.busy);
            end
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        s_run         = 0;
        r_run         = 0;
        rst_n         = 1'b0;
        bus.level_in  = 1'b1;
        bus.force_clr = 1'b0;

        test_reset();               // ends in IDLE_HIGH
        test_fall();                // ends in IDLE_LOW
        test_glitch(2);
        test_glitch(DEB - 1);
        test_force_ignored_low();
        test_force_in_pulse_s();    // ends in IDLE_HIGH
        test_force_clear();         // ends in IDLE_HIGH
        test_fall();                // ends in IDLE_LOW
        test_reset_mid_pulse();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Run-time bound.
    initial begin
        #200000;
        $display("FAIL timeout got no completion required finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
